// File: rtl/chaos_keystream_xor.sv
// Chaotic keystream XOR cipher.
// Captures four chaotic sequence words (x, y, z, w) from an external generator.
// The first DISCARD captures are dropped so the generator's transient is skipped.
// After that, an 8-bit slice of each captured word is pushed into a byte FIFO.
// Each input stream byte is XORed with one popped key byte and registered out.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run enable; low returns the block to IDLE and flushes the FIFO
//   ap_start / ap_ready run request to the generator / generator ready
//   {x,y,z,w}_seq       sequence words, each with its own *_ap_valid strobe
//   s_t*                input byte stream (valid/ready/last)
//   m_t*                output byte stream, registered, 1-cycle latency
//   drop_cnt            saturating count of captures lost to a full FIFO
//   err_align           sticky flag: some but not all word valids were seen
//   state               current FSM state (0 IDLE, 1 DISCARD, 2 RUN)
module chaos_keystream_xor #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned KEY_LSB = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DISCARD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic [WIDTH-1:0] x_seq,
  input  logic [WIDTH-1:0] y_seq,
  input  logic [WIDTH-1:0] z_seq,
  input  logic [WIDTH-1:0] w_seq,
  input  logic             x_ap_valid,
  input  logic             y_ap_valid,
  input  logic             z_ap_valid,
  input  logic             w_ap_valid,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [15:0]      drop_cnt,
  output logic             err_align,
  output logic [1:0]       state
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DiscW = (DISCARD < 2) ? 1 : $clog2(DISCARD + 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StDiscard = 2'd1, StRun = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DiscW-1:0]  disc_q, disc_d;
  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d, free;
  logic              ap_start_q, ap_start_d;
  logic [15:0]       drop_q, drop_d;
  logic              err_q, err_d;
  logic [7:0]        m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              m_tvalid_q, m_tvalid_d;

  logic              all_valid, any_valid, capture, push, drop, pop;
  logic [7:0]        keys [4];

  // Only the key slice of each word is consumed.
  logic unused_word_bits;
  assign unused_word_bits = ^{x_seq, y_seq, z_seq, w_seq};

  assign keys[0] = x_seq[KEY_LSB +: 8];
  assign keys[1] = y_seq[KEY_LSB +: 8];
  assign keys[2] = z_seq[KEY_LSB +: 8];
  assign keys[3] = w_seq[KEY_LSB +: 8];

  assign all_valid = x_ap_valid & y_ap_valid & z_ap_valid & w_ap_valid;
  assign any_valid = x_ap_valid | y_ap_valid | z_ap_valid | w_ap_valid;
  assign capture   = all_valid && (state_q != StIdle);
  // Free slots are taken before any same-cycle pop.
  assign free      = CntW'(DEPTH) - cnt_q;
  assign push      = capture && (state_q == StRun) && (free >= CntW'(4));
  assign drop      = capture && (state_q == StRun) && !push;
  assign s_tready  = (cnt_q != '0) && (!m_tvalid_q || m_tready) && (state_q == StRun);
  assign pop       = s_tvalid && s_tready;

  always_comb begin
    state_d    = state_q;
    disc_d     = disc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    err_d      = err_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;

    unique case (state_q)
      StIdle: begin
        if (ap_ready) state_d = (DISCARD == 0) ? StRun : StDiscard;
      end
      StDiscard: begin
        if (capture) begin
          disc_d = disc_q + 1'b1;
          if (disc_d == DiscW'(DISCARD)) state_d = StRun;
        end
      end
      StRun: ;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;

    if (any_valid && !all_valid && (state_q != StIdle)) err_d = 1'b1;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if (push) wptr_d = wptr_q + PtrW'(4);
    if (pop)  rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + (push ? CntW'(4) : CntW'(0)) - (pop ? CntW'(1) : CntW'(0));

    // Returning to IDLE flushes the keystream; the output register is left alone
    // so a pending beat still completes.
    if (state_d == StIdle) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      disc_d = '0;
    end

    if (pop) begin
      m_tdata_d  = s_tdata ^ mem_q[rptr_q];
      m_tlast_d  = s_tlast;
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    // Computed from next-state values so the registered output tracks the
    // current state/count.
    ap_start_d = (state_d == StDiscard) ||
                 ((state_d == StRun) && ((CntW'(DEPTH) - cnt_d) >= CntW'(8)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      disc_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ap_start_q <= 1'b0;
      drop_q     <= '0;
      err_q      <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      disc_q     <= disc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ap_start_q <= ap_start_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 4; k++) mem_q[wptr_q + PtrW'(k)] <= keys[k];
    end
  end

  assign ap_start  = ap_start_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign m_tvalid  = m_tvalid_q;
  assign drop_cnt  = drop_q;
  assign err_align = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_chaos_keystream_xor.sv
// Self-checking bench for chaos_keystream_xor: directed scenarios plus a random
// phase, checked against a queue-based reference model and a beat scoreboard.
module tb_chaos_keystream_xor;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned KEY_LSB = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DISCARD = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable, ap_start, ap_ready;
  logic [WIDTH-1:0] x_seq, y_seq, z_seq, w_seq;
  logic             x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid;
  logic [7:0]       s_tdata, m_tdata;
  logic             s_tvalid, s_tready, s_tlast;
  logic             m_tvalid, m_tready, m_tlast;
  logic [15:0]      drop_cnt;
  logic             err_align;
  logic [1:0]       state;

  chaos_keystream_xor #(
    .WIDTH(WIDTH), .KEY_LSB(KEY_LSB), .DEPTH(DEPTH), .DISCARD(DISCARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ap_start(ap_start), .ap_ready(ap_ready),
    .x_seq(x_seq), .y_seq(y_seq), .z_seq(z_seq), .w_seq(w_seq),
    .x_ap_valid(x_ap_valid), .y_ap_valid(y_ap_valid),
    .z_ap_valid(z_ap_valid), .w_ap_valid(w_ap_valid),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .drop_cnt(drop_cnt), .err_align(err_align), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] d; logic l; } beat_t;
  beat_t      sb_q [$];
  logic [7:0] key_q [$];
  logic [7:0] rx_q [$];
  int         m_st, m_disc;
  int         m_drop;
  bit         m_err, m_aps, m_ov, m_ol;
  logic [7:0] m_od;

  function automatic logic [7:0] slice(input logic [WIDTH-1:0] word);
    return 8'((word >> KEY_LSB) & 'hFF);
  endfunction

  function automatic bit model_ready();
    return (key_q.size() != 0) && (!m_ov || m_tready) && (m_st == 2);
  endfunction

  task automatic model_reset();
    m_st = 0; m_disc = 0; m_drop = 0; m_err = 0; m_aps = 0;
    m_ov = 0; m_ol = 0; m_od = 8'h00;
    key_q.delete();
    sb_q.delete();
  endtask

  task automatic model_step();
    bit all_v, any_v, rdy;
    int free, nst;
    logic [7:0] k;
    all_v = x_ap_valid && y_ap_valid && z_ap_valid && w_ap_valid;
    any_v = x_ap_valid || y_ap_valid || z_ap_valid || w_ap_valid;
    free  = DEPTH - key_q.size();
    rdy   = model_ready();
    nst   = m_st;
    if (any_v && !all_v && m_st != 0) m_err = 1;
    if (s_tvalid && rdy) begin
      k = key_q.pop_front();
      m_od = s_tdata ^ k;
      m_ol = s_tlast;
      m_ov = 1;
      sb_q.push_back('{d: m_od, l: m_ol});
    end else if (m_tready) begin
      m_ov = 0;
    end
    if (all_v && m_st == 2) begin
      if (free >= 4) begin
        key_q.push_back(slice(x_seq));
        key_q.push_back(slice(y_seq));
        key_q.push_back(slice(z_seq));
        key_q.push_back(slice(w_seq));
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (m_st == 0 && ap_ready) nst = 1;
    if (m_st == 1 && all_v) begin
      m_disc++;
      if (m_disc == DISCARD) nst = 2;
    end
    if (!enable) nst = 0;
    if (nst == 0) begin
      key_q.delete();
      m_disc = 0;
    end
    m_st  = nst;
    m_aps = (nst == 1) || (nst == 2 && (DEPTH - key_q.size()) >= 8);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit         prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    beat_t      b;
    prev_stall = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("state", 32'(state), 32'(m_st));
      chk("ap_start", 32'(ap_start), 32'(m_aps));
      chk("s_tready", 32'(s_tready), 32'(model_ready()));
      chk("m_tvalid", 32'(m_tvalid), 32'(m_ov));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("err_align", 32'(err_align), 32'(m_err));
      if (!rst_n) begin
        chk("rst_m_tdata", 32'(m_tdata), 32'h0);
        chk("rst_m_tlast", 32'(m_tlast), 32'h0);
        prev_stall = 0;
      end else begin
        if (prev_stall && m_tvalid) begin
          chk("hold_tdata", 32'(m_tdata), 32'(prev_d));
          chk("hold_tlast", 32'(m_tlast), 32'(prev_l));
        end
        if (m_tvalid && m_tready) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
          end else begin
            b = sb_q.pop_front();
            chk("sb_tdata", 32'(m_tdata), 32'(b.d));
            chk("sb_tlast", 32'(m_tlast), 32'(b.l));
          end
          rx_q.push_back(m_tdata);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] w);
    x_seq = x; y_seq = y; z_seq = z; w_seq = w;
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'hF;
    tick();
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'h0;
  endtask

  task automatic capture_rand();
    capture($urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bit got;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = s_tready;
      tick();
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no handshake, expected one within 50 cycles");
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    repeat (DISCARD) capture_rand();
  endtask

  logic [7:0] exp22 [4];
  logic [7:0] din22 [4];

  initial begin
    exp22 = '{8'h34, 8'h43, 8'h4B, 8'h0F};
    din22 = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    enable = 0; ap_ready = 0; m_tready = 0;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0;
    x_seq = 0; y_seq = 0; z_seq = 0; w_seq = 0;
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ap_start", 32'(ap_start), 32'd0);
    chk("reset_m_tvalid", 32'(m_tvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer run
    enable = 1; ap_ready = 1; m_tready = 1;
    tick();
    @(negedge clk);
    chk("enter_discard", 32'(state), 32'd1);
    tick();
    capture_rand();
    capture_rand();
    @(negedge clk);
    chk("enter_run", 32'(state), 32'd2);
    tick();
    capture(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hA5A55A5A);
    rx_q.delete();
    for (int i = 0; i < 4; i++) send(din22[i], i == 3);
    repeat (2) tick();
    chk("kat_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("kat_byte", 32'(rx_q[i]), 32'(exp22[i]));

    // Backpressure
    capture_rand();
    capture_rand();
    m_tready = 0;
    s_tdata = 8'($urandom); s_tlast = 0; s_tvalid = 1;
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_tready", 32'(s_tready), 32'd0);
      tick();
    end
    m_tready = 1;
    send(8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send(8'($urandom), i == 2);
    repeat (3) tick();

    // Overflow
    restart();
    m_tready = 0;
    repeat (6) capture_rand();
    @(negedge clk);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("ovf_ap_start", 32'(ap_start), 32'd0);
    tick();

    // Drain to 5, then push+pop in one cycle across the wrap point
    m_tready = 1;
    for (int i = 0; i < 11; i++) send(8'($urandom), 1'b0);
    x_seq = $urandom; y_seq = $urandom; z_seq = $urandom; w_seq = $urandom;
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'hF;
    s_tdata = 8'($urandom); s_tvalid = 1;
    @(negedge clk);
    chk("pp_s_tready", 32'(s_tready), 32'd1);
    tick();
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'h0;
    s_tvalid = 0;
    @(negedge clk);
    chk("pp_ap_start_cnt8", 32'(ap_start), 32'd1);
    tick();

    // Misalignment
    x_ap_valid = 1;
    tick();
    x_ap_valid = 0;
    @(negedge clk);
    chk("misalign_err", 32'(err_align), 32'd1);
    chk("misalign_cnt_kept", 32'(ap_start), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) send(8'($urandom), i == 7);
    repeat (2) tick();

    // Random phase
    for (int c = 0; c < 1500; c++) begin
      int r;
      enable   = ($urandom_range(0, 149) != 0);
      ap_ready = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 3) != 0);
      s_tvalid = $urandom_range(0, 1);
      s_tdata  = 8'($urandom);
      s_tlast  = $urandom_range(0, 1);
      x_seq = $urandom; y_seq = $urandom; z_seq = $urandom; w_seq = $urandom;
      r = $urandom_range(0, 19);
      if (r < 6)       {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'hF;
      else if (r == 6) {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'($urandom);
      else             {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'h0;
      tick();
    end
    {x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid} = 4'h0;
    s_tvalid = 0; enable = 1; ap_ready = 1; m_tready = 1;
    tick();

    // Reset mid-stream
    restart();
    capture_rand();
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    s_tdata = 8'($urandom); s_tvalid = 1;
    rst_n = 0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_err_align", 32'(err_align), 32'd0);
    tick();
    tick();
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("post_rst_discard", 32'(state), 32'd1);
    tick();
    capture_rand();
    @(negedge clk);
    chk("post_rst_still_discard", 32'(state), 32'd1);
    chk("post_rst_no_ready", 32'(s_tready), 32'd0);
    tick();
    capture_rand();
    capture_rand();
    send(8'($urandom), 1'b1);
    repeat (3) tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
